regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-port general-purpose register file for the dual-issue pipeline. It provides NRD combinational read ports and NWR posedge write ports, with a deterministic priority for same-address writes and optional same-cycle write-to-read bypass. A per-register busy scoreboard is set at issue and cleared at writeback, so the hazard unit can stall on pending producers. It sits between decode (read, issue) and writeback (write, stallW).

## Interface
Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, register address width; depth = 2^ADDR_W
- NRD, 4, number of read ports
- NWR, 2, number of write ports (one per issue lane)
- BYPASS, 1, 1 = a same-cycle write is visible on read ports; 0 = reads return stored value only

Ports (port i is packed at bits [i*W +: W]):
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- stallW  in  1  writeback stall; suppresses all writes and busy-clears this cycle
- we  in  NWR  write enable per write port
- wa  in  NWR*ADDR_W  write address per port
- wd  in  NWR*DATA_W  write data per port
- iss  in  NWR  issue valid per lane; marks the destination busy
- iss_addr  in  NWR*ADDR_W  destination register per issuing lane
- ra  in  NRD*ADDR_W  read address per port
- rd  out  NRD*DATA_W  read data per port
- rbusy  out  NRD  busy flag of the register addressed on each read port

## Operation
- Storage: 2^ADDR_W x DATA_W flops. Register 0 reads as 0, is never written and is never busy.
- Write: at posedge, if rst=0, stallW=0, we[j]=1 and wa[j]!=0, then rf[wa[j]] <= wd[j].
- Same-address writes in one cycle: the highest-index port wins. Lower ports to that address are dropped.
- Read, combinational: rd[i] = 0 if ra[i]==0.
  - Else, if BYPASS=1 and a qualifying write (we[j]=1, stallW=0, wa[j]==ra[i]) exists, rd[i] is the wd of the highest such j.
  - Else rd[i] = rf[ra[i]].
- Scoreboard, one busy bit per register:
  - Clear: a qualifying write (we[j]=1, stallW=0) to address a clears busy[a].
  - Set: iss[k]=1 with iss_addr[k]!=0 sets busy[iss_addr[k]]. Issue is not gated by stallW.
  - Set and clear to the same address in the same cycle: set wins, because a new producer supersedes the completed one.
  - Two lanes issuing the same address: the bit is set once.
- rbusy[i] = busy[ra[i]] as registered, with no bypass of same-cycle clear. rbusy[i] = 0 for ra[i]==0.
- Reset: at a posedge with rst=1, all registers and all busy bits become 0.
  - Writes and issues in that cycle are ignored.
  - Reset asserted in the middle of a write burst discards any write not yet clocked.

## Timing
- Write latency: 1 cycle. Data is stored at the posedge ending the cycle it is presented.
  - BYPASS=1: visible on rd in the same cycle.
  - BYPASS=0: visible on rd the cycle after.
- Read latency: 0 cycles, combinational from ra, and from we/wa/wd/stallW when BYPASS=1.
- Busy: set or cleared at the posedge; rbusy reflects the change from the next cycle.
- Output values after reset: every rd reads 0 (all registers 0), and every rbusy is 0.
- stallW=1 holds all register contents and busy bits except issue-driven sets.
- No combinational path from rst to rd. rst only affects state.

## Test plan
- Reset: load r5=0xDEADBEEF, assert rst for 1 cycle with we[0]=1 to r6 -> afterwards r5=0, r6=0, all rbusy=0.
- Write/bypass: BYPASS=1, we[0]=1, wa=3, wd=0x11 while ra[0]=3 -> rd[0]=0x11 in the same cycle. With BYPASS=0 -> old value this cycle, 0x11 the next cycle.
- Conflict: we=2'b11, wa[0]=wa[1]=7, wd[0]=0xA, wd[1]=0xB -> r7=0xB, and the bypassed read of 7 returns 0xB.
- Register 0: we[1]=1, wa=0, wd=0xFFFF_FFFF; iss[0]=1, iss_addr=0 -> rd of r0=0, rbusy=0.
- Scoreboard: issue r9 -> rbusy=1 the next cycle. Write r9 while reissuing r9 in the same cycle -> rbusy stays 1. Write r9 alone -> rbusy=0 the next cycle.
- Stall: stallW=1, we[0]=1 to r4 with wd=0x55, r4 busy -> r4 unchanged, busy stays 1, rd of r4 shows the old value even with BYPASS=1.

Source files
------------

// File: rtl/regfile_mp_if.sv
// Bundle of write, issue and read signals for the multi-port register file.
// The master side drives addresses, data and control; the slave returns read data and busy flags.
interface regfile_mp_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int NRD    = 4,
   parameter int NWR    = 2
);
   logic                    stallW;
   logic [NWR-1:0]          we;
   logic [NWR*ADDR_W-1:0]   wa;
   logic [NWR*DATA_W-1:0]   wd;
   logic [NWR-1:0]          iss;
   logic [NWR*ADDR_W-1:0]   iss_addr;
   logic [NRD*ADDR_W-1:0]   ra;
   logic [NRD*DATA_W-1:0]   rd;
   logic [NRD-1:0]          rbusy;

   modport master (
      output stallW, we, wa, wd, iss, iss_addr, ra,
      input  rd, rbusy
   );

   modport slave (
      input  stallW, we, wa, wd, iss, iss_addr, ra,
      output rd, rbusy
   );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port register file with highest-port-wins writes, optional write-to-read bypass
// and a per-register busy scoreboard (set at issue, cleared at writeback).
module regfile_mp #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int NRD    = 4,
   parameter int NWR    = 2,
   parameter bit BYPASS = 1'b1
) (
   input logic        clk,
   input logic        rst,
   regfile_mp_if.slave bus
);
   localparam int DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] rf_reg [DEPTH];
   logic [DEPTH-1:0]  busy_reg;
   logic [DEPTH-1:0]  busy_next;

   logic [ADDR_W-1:0] wa_a [NWR];
   logic [DATA_W-1:0] wd_a [NWR];
   logic [ADDR_W-1:0] ia_a [NWR];
   logic [NWR-1:0]    wq;

   genvar gi;
   generate
      for (gi = 0; gi < NWR; gi++) begin : g_wr
         assign wa_a[gi] = bus.wa[gi*ADDR_W +: ADDR_W];
         assign wd_a[gi] = bus.wd[gi*DATA_W +: DATA_W];
         assign ia_a[gi] = bus.iss_addr[gi*ADDR_W +: ADDR_W];
         assign wq[gi]   = bus.we[gi] & ~bus.stallW;
      end
   endgenerate

   // Clears are applied before sets so a new producer supersedes a completing one.
   always_comb begin
      busy_next = busy_reg;
      for (int j = 0; j < NWR; j++) begin
         if (wq[j]) busy_next[wa_a[j]] = 1'b0;
      end
      for (int j = 0; j < NWR; j++) begin
         if (bus.iss[j]) busy_next[ia_a[j]] = 1'b1;
      end
      busy_next[0] = 1'b0;
   end

   // Ascending port order: the last non-blocking assignment, i.e. the highest port, wins.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) rf_reg[i] <= '0;
         busy_reg <= '0;
      end else begin
         for (int j = 0; j < NWR; j++) begin
            if (wq[j] && (wa_a[j] != '0)) rf_reg[wa_a[j]] <= wd_a[j];
         end
         busy_reg <= busy_next;
      end
   end

   generate
      for (gi = 0; gi < NRD; gi++) begin : g_rd
         logic [ADDR_W-1:0] ra_g;
         logic [DATA_W-1:0] rd_g;

         assign ra_g = bus.ra[gi*ADDR_W +: ADDR_W];

         always_comb begin
            rd_g = rf_reg[ra_g];
            if (BYPASS) begin
               for (int j = 0; j < NWR; j++) begin
                  if (wq[j] && (wa_a[j] == ra_g)) rd_g = wd_a[j];
               end
            end
            if (ra_g == '0) rd_g = '0;
         end

         assign bus.rd[gi*DATA_W +: DATA_W] = rd_g;
         assign bus.rbusy[gi] = (ra_g != '0) & busy_reg[ra_g];
      end
   endgenerate
endmodule

// File: tb/tb_regfile_mp.sv
// Drives identical stimulus into a bypassing and a non-bypassing register file and
// compares every read port against an array-based reference model.
module tb_regfile_mp;
   localparam int DW = 32;
   localparam int AW = 5;
   localparam int NR = 4;
   localparam int NW = 2;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   regfile_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NRD(NR), .NWR(NW)) ifb ();
   regfile_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NRD(NR), .NWR(NW)) ifn ();

   regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NRD(NR), .NWR(NW), .BYPASS(1'b1)) u_byp (
      .clk(clk), .rst(rst), .bus(ifb)
   );
   regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NRD(NR), .NWR(NW), .BYPASS(1'b0)) u_nob (
      .clk(clk), .rst(rst), .bus(ifn)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   bit chk_en = 1'b0;

   logic          rst_v;
   logic          stall_v;
   logic [NW-1:0] we_v;
   logic [NW-1:0] iss_v;
   logic [AW-1:0] wa_v [NW];
   logic [DW-1:0] wd_v [NW];
   logic [AW-1:0] ia_v [NW];
   logic [AW-1:0] ra_v [NR];

   logic [DW-1:0] m_rf [32];
   bit            m_busy [32];

   task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
      end
   endtask

   task automatic clear_in();
      rst_v = 1'b0;
      stall_v = 1'b0;
      we_v = '0;
      iss_v = '0;
      for (int j = 0; j < NW; j++) begin
         wa_v[j] = '0; wd_v[j] = '0; ia_v[j] = '0;
      end
      for (int i = 0; i < NR; i++) ra_v[i] = '0;
   endtask

   task automatic setup();
      logic [NW*AW-1:0] wa_p, ia_p;
      logic [NW*DW-1:0] wd_p;
      logic [NR*AW-1:0] ra_p;
      for (int j = 0; j < NW; j++) begin
         wa_p[j*AW +: AW] = wa_v[j];
         ia_p[j*AW +: AW] = ia_v[j];
         wd_p[j*DW +: DW] = wd_v[j];
      end
      for (int i = 0; i < NR; i++) ra_p[i*AW +: AW] = ra_v[i];
      rst = rst_v;
      ifb.stallW = stall_v; ifn.stallW = stall_v;
      ifb.we = we_v;        ifn.we = we_v;
      ifb.wa = wa_p;        ifn.wa = wa_p;
      ifb.wd = wd_p;        ifn.wd = wd_p;
      ifb.iss = iss_v;      ifn.iss = iss_v;
      ifb.iss_addr = ia_p;  ifn.iss_addr = ia_p;
      ifb.ra = ra_p;        ifn.ra = ra_p;
      #1;
   endtask

   function automatic logic [DW-1:0] exp_rd(input int i, input bit byp);
      logic [AW-1:0] a;
      a = ra_v[i];
      if (a == 0) return '0;
      if (byp && !stall_v) begin
         for (int j = NW - 1; j >= 0; j--) begin
            if (we_v[j] && wa_v[j] == a) return wd_v[j];
         end
      end
      return m_rf[a];
   endfunction

   function automatic logic [DW-1:0] exp_busy(input int i);
      if (ra_v[i] == 0) return '0;
      return {31'd0, m_busy[ra_v[i]]};
   endfunction

   function automatic logic [DW-1:0] rd_b(input int i);
      return ifb.rd[i*DW +: DW];
   endfunction

   function automatic logic [DW-1:0] rd_n(input int i);
      return ifn.rd[i*DW +: DW];
   endfunction

   task automatic update_model();
      bit set_a [32];
      bit clr_a [32];
      if (rst_v) begin
         for (int a = 0; a < 32; a++) begin
            m_rf[a] = '0; m_busy[a] = 1'b0;
         end
         chk_en = 1'b1;
      end else begin
         for (int a = 0; a < 32; a++) begin
            set_a[a] = 1'b0; clr_a[a] = 1'b0;
         end
         if (!stall_v) begin
            for (int j = 0; j < NW; j++) begin
               if (we_v[j]) begin
                  clr_a[wa_v[j]] = 1'b1;
                  if (wa_v[j] != 0) m_rf[wa_v[j]] = wd_v[j];
               end
            end
         end
         for (int j = 0; j < NW; j++) if (iss_v[j]) set_a[ia_v[j]] = 1'b1;
         for (int a = 1; a < 32; a++) begin
            if (set_a[a]) m_busy[a] = 1'b1;
            else if (clr_a[a]) m_busy[a] = 1'b0;
         end
      end
   endtask

   task automatic finish_cycle();
      if (chk_en) begin
         for (int i = 0; i < NR; i++) begin
            check($sformatf("byp_rd%0d", i), rd_b(i), exp_rd(i, 1'b1));
            check($sformatf("nob_rd%0d", i), rd_n(i), exp_rd(i, 1'b0));
            check($sformatf("byp_busy%0d", i), {31'd0, ifb.rbusy[i]}, exp_busy(i));
            check($sformatf("nob_busy%0d", i), {31'd0, ifn.rbusy[i]}, exp_busy(i));
         end
      end
      $display("cyc %0d rst=%b stall=%b we=%b wa=%0d/%0d iss=%b ia=%0d/%0d ra=%0d/%0d/%0d/%0d",
               cyc, rst_v, stall_v, we_v, wa_v[0], wa_v[1], iss_v, ia_v[0], ia_v[1],
               ra_v[0], ra_v[1], ra_v[2], ra_v[3]);
      @(posedge clk);
      update_model();
      cyc++;
      #1;
   endtask

   task automatic cycle();
      setup();
      finish_cycle();
   endtask

   initial begin
      for (int a = 0; a < 32; a++) begin
         m_rf[a] = '0; m_busy[a] = 1'b0;
      end
      clear_in();
      rst_v = 1'b1;
      cycle();
      cycle();

      // Reset discards a pending write and clears stored data
      clear_in(); we_v[0] = 1'b1; wa_v[0] = 5; wd_v[0] = 32'hDEADBEEF; cycle();
      clear_in(); rst_v = 1'b1; we_v[0] = 1'b1; wa_v[0] = 6; wd_v[0] = 32'h12345678; cycle();
      clear_in(); ra_v[0] = 5; ra_v[1] = 6; setup();
      check("rst_r5", rd_n(0), 32'h0);
      check("rst_r6", rd_n(1), 32'h0);
      check("rst_busy", {28'd0, ifn.rbusy}, 32'h0);
      finish_cycle();

      // Bypass vs. registered read
      clear_in(); we_v[0] = 1'b1; wa_v[0] = 3; wd_v[0] = 32'h11; ra_v[0] = 3; setup();
      check("byp_same", rd_b(0), 32'h11);
      check("nob_same", rd_n(0), 32'h0);
      finish_cycle();
      clear_in(); ra_v[0] = 3; setup();
      check("nob_next", rd_n(0), 32'h11);
      finish_cycle();

      // Same-address conflict
      clear_in(); we_v = 2'b11; wa_v[0] = 7; wa_v[1] = 7; wd_v[0] = 32'hA; wd_v[1] = 32'hB;
      ra_v[0] = 7; setup();
      check("conf_byp", rd_b(0), 32'hB);
      finish_cycle();
      clear_in(); ra_v[0] = 7; setup();
      check("conf_store", rd_n(0), 32'hB);
      finish_cycle();

      // Register 0
      clear_in(); we_v[1] = 1'b1; wa_v[1] = 0; wd_v[1] = 32'hFFFF_FFFF; iss_v[0] = 1'b1; ia_v[0] = 0;
      cycle();
      clear_in(); setup();
      check("r0_rd", rd_b(0), 32'h0);
      check("r0_busy", {31'd0, ifb.rbusy[0]}, 32'h0);
      finish_cycle();

      // Scoreboard
      clear_in(); iss_v[0] = 1'b1; ia_v[0] = 9; cycle();
      clear_in(); ra_v[0] = 9; we_v[0] = 1'b1; wa_v[0] = 9; wd_v[0] = 32'h99;
      iss_v[1] = 1'b1; ia_v[1] = 9; setup();
      check("sb_set", {31'd0, ifb.rbusy[0]}, 32'h1);
      finish_cycle();
      clear_in(); ra_v[0] = 9; we_v[0] = 1'b1; wa_v[0] = 9; wd_v[0] = 32'h9A; setup();
      check("sb_setwins", {31'd0, ifb.rbusy[0]}, 32'h1);
      finish_cycle();
      clear_in(); ra_v[0] = 9; setup();
      check("sb_clear", {31'd0, ifb.rbusy[0]}, 32'h0);
      finish_cycle();

      // Stall holds data and busy
      clear_in(); we_v[0] = 1'b1; wa_v[0] = 4; wd_v[0] = 32'h22; iss_v[0] = 1'b1; ia_v[0] = 4; cycle();
      clear_in(); stall_v = 1'b1; we_v[0] = 1'b1; wa_v[0] = 4; wd_v[0] = 32'h55; ra_v[0] = 4; setup();
      check("stall_byp", rd_b(0), 32'h22);
      check("stall_busy", {31'd0, ifb.rbusy[0]}, 32'h1);
      finish_cycle();
      clear_in(); ra_v[0] = 4; setup();
      check("stall_hold", rd_n(0), 32'h22);
      check("stall_busy2", {31'd0, ifn.rbusy[0]}, 32'h1);
      finish_cycle();

      // Randomized traffic on a narrow address range to provoke conflicts
      for (int n = 0; n < 400; n++) begin
         clear_in();
         rst_v = ($urandom_range(0, 99) < 2);
         stall_v = ($urandom_range(0, 99) < 20);
         we_v = NW'($urandom);
         iss_v = NW'($urandom);
         for (int j = 0; j < NW; j++) begin
            wa_v[j] = AW'($urandom_range(0, 7));
            ia_v[j] = AW'($urandom_range(0, 7));
            wd_v[j] = $urandom;
         end
         for (int i = 0; i < NR; i++) begin
            ra_v[i] = ($urandom_range(0, 9) == 0) ? AW'(31) : AW'($urandom_range(0, 7));
         end
         cycle();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
